// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, class decode, FSM states.
package alu_pkg;

  localparam logic [3:0] FUN_ADD  = 4'b0000;
  localparam logic [3:0] FUN_SUB  = 4'b0001;
  localparam logic [3:0] FUN_MUL  = 4'b0010;
  localparam logic [3:0] FUN_DIV  = 4'b0011;
  localparam logic [3:0] FUN_AND  = 4'b0100;
  localparam logic [3:0] FUN_OR   = 4'b0101;
  localparam logic [3:0] FUN_NAND = 4'b0110;
  localparam logic [3:0] FUN_NOR  = 4'b0111;
  localparam logic [3:0] FUN_XOR  = 4'b1000;
  localparam logic [3:0] FUN_XNOR = 4'b1001;
  localparam logic [3:0] FUN_EQ   = 4'b1010;
  localparam logic [3:0] FUN_GT   = 4'b1011;
  localparam logic [3:0] FUN_LT   = 4'b1100;
  localparam logic [3:0] FUN_SHR  = 4'b1101;
  localparam logic [3:0] FUN_SHL  = 4'b1110;
  localparam logic [3:0] FUN_NOP  = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } alu_state_e;

  function automatic logic is_arith(input logic [3:0] fun);
    return (fun <= FUN_DIV);
  endfunction

  function automatic logic is_logic(input logic [3:0] fun);
    return (fun >= FUN_AND) && (fun <= FUN_XNOR);
  endfunction

  function automatic logic is_cmp(input logic [3:0] fun);
    return (fun >= FUN_EQ) && (fun <= FUN_LT);
  endfunction

  function automatic logic is_shift(input logic [3:0] fun);
    return (fun >= FUN_SHR) && (fun <= FUN_SHL);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. done is asserted combinationally
// during the cycle whose edge performs the final iteration; quotient/remainder carry that
// final iteration's result so the parent can register it on the same edge.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] quo_it_s;
  logic [WIDTH-1:0] rem_it_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
    if (trial_s[WIDTH]) begin
      rem_it_s = shifted_s[WIDTH-1:0];
      quo_it_s = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_it_s = trial_s[WIDTH-1:0];
      quo_it_s = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state: load operands on start, iterate while busy, stop after WIDTH steps.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      quo_d = quo_it_s;
      rem_d = rem_it_s;
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (start) begin
      quo_d  = dividend;
      rem_d  = {WIDTH{1'b0}};
      dvs_d  = divisor;
      cnt_d  = CNT_FULL;
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= {WIDTH{1'b0}};
      rem_q  <= {WIDTH{1'b0}};
      dvs_q  <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CNT_ONE);
  assign quotient  = quo_it_s;
  assign remainder = rem_it_s;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle ops registered on the accepting edge,
// divide by nonzero handed to an iterative divider and registered on completion.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic [2*WIDTH-1:0] ALU_OUT,
  output logic               OUT_VALID,
  output logic               BUSY,
  output logic               Arith_flag,
  output logic               Logic_flag,
  output logic               CMP_flag,
  output logic               Shift_flag,
  output logic               DIV_ZERO
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [W2-1:0] RES_ZERO = {W2{1'b0}};
  localparam logic [W2-1:0] RES_EQ   = {{(W2-2){1'b0}}, 2'd1};
  localparam logic [W2-1:0] RES_GT   = {{(W2-2){1'b0}}, 2'd2};
  localparam logic [W2-1:0] RES_LT   = {{(W2-2){1'b0}}, 2'd3};

  alu_state_e     state_q, state_d;
  logic [W2-1:0]  alu_out_q, alu_out_d;
  logic [3:0]     class_q, class_d;    // {arith, logic, cmp, shift}
  logic           div_zero_q, div_zero_d;
  logic           out_valid_q, out_valid_d;

  logic [W2-1:0]    a_ext_s, b_ext_s, op_res_s;
  logic [WIDTH:0]   sub_s;
  logic             div_start_s, div_busy_s, div_done_s;
  logic [WIDTH-1:0] div_quo_s, div_rem_s;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (div_start_s),
    .dividend  (A),
    .divisor   (B),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Single-cycle datapath; the DIV entry is only used for the divide-by-zero case.
  always_comb begin
    a_ext_s  = {{WIDTH{1'b0}}, A};
    b_ext_s  = {{WIDTH{1'b0}}, B};
    sub_s    = {1'b0, A} - {1'b0, B};
    op_res_s = RES_ZERO;
    case (ALU_FUN)
      FUN_ADD:  op_res_s = a_ext_s + b_ext_s;
      FUN_SUB:  op_res_s = {{(WIDTH-1){1'b0}}, sub_s};
      FUN_MUL:  op_res_s = a_ext_s * b_ext_s;
      FUN_DIV:  op_res_s = {A, {WIDTH{1'b1}}};
      FUN_AND:  op_res_s = {{WIDTH{1'b0}}, A & B};
      FUN_OR:   op_res_s = {{WIDTH{1'b0}}, A | B};
      FUN_NAND: op_res_s = {{WIDTH{1'b0}}, ~(A & B)};
      FUN_NOR:  op_res_s = {{WIDTH{1'b0}}, ~(A | B)};
      FUN_XOR:  op_res_s = {{WIDTH{1'b0}}, A ^ B};
      FUN_XNOR: op_res_s = {{WIDTH{1'b0}}, ~(A ^ B)};
      FUN_EQ:   op_res_s = (A == B) ? RES_EQ : RES_ZERO;
      FUN_GT:   op_res_s = (A > B)  ? RES_GT : RES_ZERO;
      FUN_LT:   op_res_s = (A < B)  ? RES_LT : RES_ZERO;
      FUN_SHR:  op_res_s = {{WIDTH{1'b0}}, A >> 1'b1};
      FUN_SHL:  op_res_s = {{WIDTH{1'b0}}, A << 1'b1};
      FUN_NOP:  op_res_s = RES_ZERO;
      default:  op_res_s = RES_ZERO;
    endcase
  end

  // Control FSM: accept requests in IDLE, wait for the divider in DIV.
  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    class_d     = class_q;
    div_zero_d  = div_zero_q;
    out_valid_d = 1'b0;
    div_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN && !div_busy_s) begin
          if ((ALU_FUN == FUN_DIV) && (B != {WIDTH{1'b0}})) begin
            div_start_s = 1'b1;
            state_d     = ST_DIV;
          end else begin
            alu_out_d   = op_res_s;
            class_d     = {is_arith(ALU_FUN), is_logic(ALU_FUN),
                           is_cmp(ALU_FUN), is_shift(ALU_FUN)};
            div_zero_d  = (ALU_FUN == FUN_DIV);
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          alu_out_d   = {div_rem_s, div_quo_s};
          class_d     = 4'b1000;
          div_zero_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and state registers; reset aborts any divide in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      alu_out_q   <= RES_ZERO;
      class_q     <= 4'b0000;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      class_q     <= class_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ALU_OUT    = alu_out_q;
  assign OUT_VALID  = out_valid_q;
  assign BUSY       = (state_q == ST_DIV);
  assign Arith_flag = class_q[3];
  assign Logic_flag = class_q[2];
  assign CMP_flag   = class_q[1];
  assign Shift_flag = class_q[0];
  assign DIV_ZERO   = div_zero_q;

endmodule
